// File: rtl/sc_step_sequencer_pkg.sv
// Shared definitions for the step sequencer and the game-object mover.
package sc_step_sequencer_pkg;

   localparam int DIV_DATAWIDTH       = 4;
   localparam int STEPCOUNT_DATAWIDTH = 8;

   // 2'b11 is unused; the FSM recovers from it to IDLE.
   typedef enum logic [1:0] {
      STATE_IDLE     = 2'b00,
      STATE_RUN      = 2'b01,
      STATE_WAIT_ACK = 2'b10
   } state_t;

endpackage

// File: rtl/sc_step_sequencer_acc.sv
// Tick accumulator with terminal compare against a latched divisor.
// A divisor of 0 is latched as 1, so terminal is reached on every tick.
module sc_step_sequencer_acc #(
   parameter int DIV_DATAWIDTH = sc_step_sequencer_pkg::DIV_DATAWIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     tick,
   input  logic                     latch,
   input  logic [DIV_DATAWIDTH-1:0] divisor,
   output logic                     terminal
);

   logic [DIV_DATAWIDTH-1:0] tick_acc;
   logic [DIV_DATAWIDTH-1:0] div_lat;
   logic [DIV_DATAWIDTH-1:0] div_eff;

   assign div_eff  = (divisor == '0) ? DIV_DATAWIDTH'(1) : divisor;
   assign terminal = (tick_acc == div_lat - DIV_DATAWIDTH'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_acc <= '0;
         div_lat  <= DIV_DATAWIDTH'(1);
      end else begin
         if (clear)
            tick_acc <= '0;
         else if (tick)
            tick_acc <= tick_acc + DIV_DATAWIDTH'(1);
         if (latch)
            div_lat <= div_eff;
      end
   end

endmodule

// File: rtl/sc_step_sequencer.sv
// Divides counter ticks by a programmable divisor and issues req/ack step requests.
// Holds the tick counter cleared whenever it is not accumulating ticks.
module sc_step_sequencer #(
   parameter int DIV_DATAWIDTH       = sc_step_sequencer_pkg::DIV_DATAWIDTH,
   parameter int STEPCOUNT_DATAWIDTH = sc_step_sequencer_pkg::STEPCOUNT_DATAWIDTH
) (
   input  logic                           SC_STEPSEQ_CLOCK_50,
   input  logic                           SC_STEPSEQ_RESET_InHigh,
   input  logic                           SC_STEPSEQ_eoc_InLow,
   input  logic                           SC_STEPSEQ_run_InHigh,
   input  logic [DIV_DATAWIDTH-1:0]       SC_STEPSEQ_divisor_InBUS,
   input  logic                           SC_STEPSEQ_stepAck_InHigh,
   output logic                           SC_STEPSEQ_count_OutLow,
   output logic                           SC_STEPSEQ_stepReq_OutHigh,
   output logic [STEPCOUNT_DATAWIDTH-1:0] SC_STEPSEQ_stepCount_OutBUS,
   output logic                           SC_STEPSEQ_overrun_OutHigh
);

   import sc_step_sequencer_pkg::*;

   state_t state;
   logic   hold_entry;
   logic   tick_seen;
   logic   terminal;
   logic   acc_clear;
   logic   acc_tick;
   logic   acc_latch;

   assign tick_seen = ~SC_STEPSEQ_eoc_InLow;

   assign acc_clear = (state != STATE_RUN) || !SC_STEPSEQ_run_InHigh || (tick_seen && terminal);
   assign acc_tick  = (state == STATE_RUN) && SC_STEPSEQ_run_InHigh && tick_seen && !terminal;
   assign acc_latch = ((state == STATE_IDLE) && SC_STEPSEQ_run_InHigh) ||
                      ((state == STATE_WAIT_ACK) && SC_STEPSEQ_stepAck_InHigh);

   sc_step_sequencer_acc #(
      .DIV_DATAWIDTH(DIV_DATAWIDTH)
   ) u_acc (
      .clk      (SC_STEPSEQ_CLOCK_50),
      .reset    (SC_STEPSEQ_RESET_InHigh),
      .clear    (acc_clear),
      .tick     (acc_tick),
      .latch    (acc_latch),
      .divisor  (SC_STEPSEQ_divisor_InBUS),
      .terminal (terminal)
   );

   // hold_entry marks the first cycle in a held state, when a tick already in flight
   // from the counter is still legitimate and must not raise overrun.
   always_ff @(posedge SC_STEPSEQ_CLOCK_50) begin
      if (SC_STEPSEQ_RESET_InHigh) begin
         state                       <= STATE_IDLE;
         hold_entry                  <= 1'b1;
         SC_STEPSEQ_count_OutLow     <= 1'b1;
         SC_STEPSEQ_stepReq_OutHigh  <= 1'b0;
         SC_STEPSEQ_stepCount_OutBUS <= '0;
         SC_STEPSEQ_overrun_OutHigh  <= 1'b0;
      end else begin
         hold_entry <= 1'b0;
         if ((state == STATE_IDLE || state == STATE_WAIT_ACK) && tick_seen && !hold_entry)
            SC_STEPSEQ_overrun_OutHigh <= 1'b1;

         case (state)
            STATE_IDLE: begin
               SC_STEPSEQ_count_OutLow <= 1'b1;
               if (SC_STEPSEQ_run_InHigh) begin
                  state                   <= STATE_RUN;
                  SC_STEPSEQ_count_OutLow <= 1'b0;
               end
            end
            STATE_RUN: begin
               SC_STEPSEQ_count_OutLow <= 1'b0;
               if (!SC_STEPSEQ_run_InHigh) begin
                  state                   <= STATE_IDLE;
                  SC_STEPSEQ_count_OutLow <= 1'b1;
                  hold_entry              <= 1'b1;
               end else if (tick_seen && terminal) begin
                  state                      <= STATE_WAIT_ACK;
                  SC_STEPSEQ_count_OutLow    <= 1'b1;
                  SC_STEPSEQ_stepReq_OutHigh <= 1'b1;
                  hold_entry                 <= 1'b1;
               end
            end
            STATE_WAIT_ACK: begin
               SC_STEPSEQ_count_OutLow    <= 1'b1;
               SC_STEPSEQ_stepReq_OutHigh <= 1'b1;
               if (SC_STEPSEQ_stepAck_InHigh) begin
                  SC_STEPSEQ_stepReq_OutHigh  <= 1'b0;
                  SC_STEPSEQ_stepCount_OutBUS <= SC_STEPSEQ_stepCount_OutBUS + 1'b1;
                  if (SC_STEPSEQ_run_InHigh) begin
                     state                   <= STATE_RUN;
                     SC_STEPSEQ_count_OutLow <= 1'b0;
                  end else begin
                     state <= STATE_IDLE;
                  end
               end
            end
            default: begin
               state                      <= STATE_IDLE;
               SC_STEPSEQ_count_OutLow    <= 1'b1;
               SC_STEPSEQ_stepReq_OutHigh <= 1'b0;
               hold_entry                 <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/sc_step_sequencer.md
Name: sc_step_sequencer

Overview:
- Consumer end of the free-running tick counter interface.
- Takes the counter's active-low end-of-count tick and drives the counter's clear input.
- Divides ticks by a programmable divisor and issues one step request per N ticks to a game-object mover, using a req/ack handshake.
- Sits between the tick counter and the invader/bullet movement logic; it sets game speed by changing the divisor.

Parameters:
- DIV_DATAWIDTH, 4: width of the ticks-per-step divisor and the internal tick accumulator.
- STEPCOUNT_DATAWIDTH, 8: width of the completed-step counter output.

Ports:
- SC_STEPSEQ_CLOCK_50  in  1  system clock; all logic on its rising edge.
- SC_STEPSEQ_RESET_InHigh  in  1  reset; synchronous, active-high.
- SC_STEPSEQ_eoc_InLow  in  1  end-of-count tick from the counter; low for one cycle per tick.
- SC_STEPSEQ_run_InHigh  in  1  level enable; 1 = generate steps.
- SC_STEPSEQ_divisor_InBUS  in  DIV_DATAWIDTH  ticks per step; value 0 is treated as 1.
- SC_STEPSEQ_stepAck_InHigh  in  1  mover acknowledges a step; sampled only in WAIT_ACK.
- SC_STEPSEQ_count_OutLow  out  1  to the counter's clear input; 1 = hold counter cleared, 0 = count.
- SC_STEPSEQ_stepReq_OutHigh  out  1  step request to the mover; held until acked.
- SC_STEPSEQ_stepCount_OutBUS  out  STEPCOUNT_DATAWIDTH  number of completed steps; wraps.
- SC_STEPSEQ_overrun_OutHigh  out  1  sticky fault flag.

Behaviour:
- All outputs are registered. Reset is synchronous: on a clock edge with RESET_InHigh=1, the block ignores all other inputs that cycle.
- Reset values: state=IDLE, count_OutLow=1, stepReq=0, stepCount=0, overrun=0, tick_acc=0, div_lat=1.
- div_eff = (divisor==0) ? 1 : divisor.
- IDLE:
  - Outputs: count_OutLow=1, tick_acc=0.
  - When run=1: latch div_lat=div_eff and go to RUN. count_OutLow=0 from the next cycle.
- RUN:
  - count_OutLow=0.
  - When run=0: go to IDLE, clear tick_acc, set count_OutLow=1 next cycle. run has priority over a same-cycle tick, so that tick is dropped.
  - When eoc_InLow=0 and tick_acc==div_lat-1: go to WAIT_ACK, set tick_acc=0, stepReq=1, count_OutLow=1 next cycle. Latency is tick cycle +1.
  - When eoc_InLow=0 otherwise: tick_acc+1.
- WAIT_ACK:
  - stepReq=1 and count_OutLow=1; the counter is frozen cleared, so no ticks are lost or accumulated.
  - When stepAck=1:
    - Next cycle: stepReq=0 and stepCount+1, wrapping modulo 2^STEPCOUNT_DATAWIDTH (255 -> 0).
    - Re-latch div_lat=div_eff.
    - If run=1, go to RUN (count_OutLow=0). Otherwise go to IDLE.
  - Dropping run in WAIT_ACK does not abort the handshake: the block stays in WAIT_ACK until ack.
  - Ack already high on the cycle stepReq rises is accepted on the first WAIT_ACK cycle. The minimum req pulse is 1 cycle.
  - stepAck outside WAIT_ACK is ignored.
- Divisor changes during RUN take effect only at the next latch point (IDLE->RUN or step completion), never mid-accumulation.
- overrun:
  - Set to 1 if eoc_InLow=0 is sampled in IDLE or WAIT_ACK, where the counter is held cleared. This indicates a wiring or counter fault.
  - Exception: the first cycle after entering a held state is exempt, to absorb the registered clear.
  - Sticky until reset.
- Reset asserted mid-handshake: stepReq drops next edge and stepCount is cleared. The mover must tolerate a req withdrawn without ack.

Decomposition:
- Shared package holds:
  - state encoding constants: STATE_IDLE=2'b00, STATE_RUN=2'b01, STATE_WAIT_ACK=2'b10. 2'b11 is illegal and recovers to IDLE.
  - default widths DIV_DATAWIDTH=4 and STEPCOUNT_DATAWIDTH=8, shared with the mover.
- One sub-module is natural: sc_step_sequencer_acc, the tick accumulator with terminal-compare, clear, and divisor-latch.
- The FSM and output registers stay in the top.

Test Plan:
- Reset held 3 cycles, then released with run=0 -> count_OutLow=1, stepReq=0, stepCount=0, overrun=0; the block stays in IDLE.
- divisor=3, run=1, eoc low pulses every 10 cycles, ack returned 2 cycles after req -> stepReq rises 1 cycle after every 3rd tick; stepCount reaches 4 after 12 ticks; count_OutLow=1 exactly during each WAIT_ACK.
- divisor=0, run=1 -> every single tick yields a step (behaves as divisor 1); stepCount 255->0 after 256 acked steps.
- run dropped while stepReq=1, ack 5 cycles later -> stepReq held 5 cycles, then drops; stepCount+1; state IDLE with count_OutLow=1.
- divisor changed 3->2 after the 1st tick of a step -> the current step still needs 3 ticks, the following step needs 2.
- Forced eoc low for 1 cycle during WAIT_ACK, 2 cycles after entry -> overrun=1 and it stays 1 until a synchronous reset returns it to 0.
